alu_operand_stage: RTL and testbench
====================================

Name: alu_operand_stage

Overview:
- ID/EX pipeline stage that directly feeds the ALU.
- Registers decoded operands, register specifiers and the ALU control code from decode, with stall (hold) and flush (bubble) control.
- Applies EX/MEM and MEM/WB forwarding, immediate extension and shift-amount selection to produce the ALU's input1, input2 and alu_control.
- Raises a load-use hazard flag to the hazard unit.

Parameters:
- DATA_W, 32, datapath width; immediate and shamt extend to this width.
- REG_W, 5, register specifier width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  hold stage contents.
- flush  in  1  insert bubble.
- id_valid  in  1  decode slot holds a real instruction.
- id_alu_control  in  5  ALU operation code.
- id_rs, id_rt, id_rd  in  REG_W each  source and destination specifiers.
- id_rs_data, id_rt_data  in  DATA_W each  register-file read data.
- id_imm  in  16  raw immediate.
- id_shamt  in  5  shift amount.
- id_reg_write, id_mem_read, id_mem_write  in  1 each  control bits.
- exmem_reg_write  in  1;  exmem_rd  in  REG_W;  exmem_result  in  DATA_W  EX/MEM forward source.
- memwb_reg_write  in  1;  memwb_rd  in  REG_W;  memwb_data  in  DATA_W  MEM/WB forward source.
- alu_input1, alu_input2  out  DATA_W each  ALU operands.
- alu_control  out  5  registered code, forced 0 when the slot is invalid.
- ex_valid, ex_reg_write, ex_mem_read, ex_mem_write  out  1 each  registered control bits.
- ex_rd  out  REG_W  registered destination.
- ex_store_data  out  DATA_W  forwarded rt value.
- load_use_hazard  out  1  combinational request to stall decode.

Behaviour:
- Only clock and reset: clk, and reset is synchronous, active-high.
- Register update at posedge clk, priority reset > flush > stall > load:
  - reset: all stage registers 0, so ex_valid=0, alu_control=0, ex_reg_write=0, ex_mem_read=0, ex_mem_write=0, ex_rd=0, and alu_input1, alu_input2 and ex_store_data read 0.
  - flush: same values as reset (bubble); flush wins over a simultaneous stall.
  - stall: all registers hold.
  - otherwise: capture all id_* inputs. Control bits are captured ANDed with id_valid.
- Latency: one cycle from id_* to outputs.
  - Forwarding muxes and operand selection are combinational on registered values plus the current exmem_*/memwb_* inputs.
- Forwarding for the registered rs (same rule for rt):
  - Value is exmem_result if exmem_reg_write and exmem_rd==rs and rs!=0.
  - Else memwb_data if memwb_reg_write and memwb_rd==rs and rs!=0.
  - Else the registered register data.
  - EX/MEM has priority when both sources match. Register 0 is never forwarded and reads as the captured data.
- Operand select by registered code:
  - 00001, 00010, 00011, 00100, 00101: input1=fwd_rs, input2=fwd_rt.
  - 00110 (slti), 00111 (addi): input1=fwd_rs, input2=sign-extended imm.
  - 01000 (andi), 01001 (ori): input1=fwd_rs, input2=zero-extended imm.
  - 01010, 01011, 01100 (shifts): input1=fwd_rt, input2=zero-extended shamt.
  - 01101 (lui): input1=0, input2=zero-extended imm.
  - Any other code: both operands 0.
- ex_store_data = fwd_rt always.
- load_use_hazard = ex_valid & ex_mem_read & ex_rd!=0 & id_valid & (ex_rd==id_rs | ex_rd==id_rt).
  - Asserted combinationally in the same cycle. The stage does not stall itself.
- Reset asserted mid-operation discards the held instruction; the first capture happens on the first edge with reset low.

Test Plan:
- Reset sequence, with id_valid=1 driven during reset: ex_valid=0, alu_control=0, alu_input1=alu_input2=0. First edge after release captures the instruction.
- addi id_rs=3 (data 0x10), id_imm=0xFFFF, no forwards: next cycle alu_input1=0x10, alu_input2=0xFFFFFFFF, alu_control=00111. ori with id_imm=0xFFFF gives alu_input2=0x0000FFFF.
- Double forward: add with rs=rt=5; exmem rd=5, result=0xAAAA0000; memwb rd=5, data=0x1234. Requires alu_input1=alu_input2=0xAAAA0000. With exmem_reg_write=0, both operands are 0x1234. With rs=0 and exmem_rd=0, the captured data is used.
- Shifts and lui:
  - sll with rt data 0x1, shamt=31: alu_input1=0x1, alu_input2=31.
  - lui imm=0x8000: alu_input1=0, alu_input2=0x00008000.
- Stall/flush: capture instr A. Stall 3 cycles while id_* changes to B: outputs stay A. Assert flush and stall together: next cycle ex_valid=0, ex_reg_write=0, alu_control=0.
- Load-use: stage holds a load with ex_rd=7, ex_mem_read=1; decode id_rs=7, id_valid=1 gives load_use_hazard=1 in that cycle. id_rs=id_rt=8 gives 0. ex_rd=0 gives 0.

Source files
------------

// File: rtl/alu_operand_stage.sv
// ID/EX operand stage: registers the decoded instruction and produces ALU operands.
// Applies EX/MEM and MEM/WB forwarding and immediate/shamt extension.
// Flags load-use hazards back to decode.
module alu_operand_stage #(
   parameter int DATA_W = 32,
   parameter int REG_W  = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              stall,
   input  logic              flush,
   input  logic              id_valid,
   input  logic [4:0]        id_alu_control,
   input  logic [REG_W-1:0]  id_rs,
   input  logic [REG_W-1:0]  id_rt,
   input  logic [REG_W-1:0]  id_rd,
   input  logic [DATA_W-1:0] id_rs_data,
   input  logic [DATA_W-1:0] id_rt_data,
   input  logic [15:0]       id_imm,
   input  logic [4:0]        id_shamt,
   input  logic              id_reg_write,
   input  logic              id_mem_read,
   input  logic              id_mem_write,
   input  logic              exmem_reg_write,
   input  logic [REG_W-1:0]  exmem_rd,
   input  logic [DATA_W-1:0] exmem_result,
   input  logic              memwb_reg_write,
   input  logic [REG_W-1:0]  memwb_rd,
   input  logic [DATA_W-1:0] memwb_data,
   output logic [DATA_W-1:0] alu_input1,
   output logic [DATA_W-1:0] alu_input2,
   output logic [4:0]        alu_control,
   output logic              ex_valid,
   output logic              ex_reg_write,
   output logic              ex_mem_read,
   output logic              ex_mem_write,
   output logic [REG_W-1:0]  ex_rd,
   output logic [DATA_W-1:0] ex_store_data,
   output logic              load_use_hazard
);

   localparam logic [4:0] OP_R_FIRST = 5'b00001;
   localparam logic [4:0] OP_R_LAST  = 5'b00101;
   localparam logic [4:0] OP_SLTI    = 5'b00110;
   localparam logic [4:0] OP_ADDI    = 5'b00111;
   localparam logic [4:0] OP_ANDI    = 5'b01000;
   localparam logic [4:0] OP_ORI     = 5'b01001;
   localparam logic [4:0] OP_SLL     = 5'b01010;
   localparam logic [4:0] OP_SRL     = 5'b01011;
   localparam logic [4:0] OP_SRA     = 5'b01100;
   localparam logic [4:0] OP_LUI     = 5'b01101;

   // Stage registers
   logic                     vld_p0;
   logic [4:0]               alu_ctrl_p0;
   logic [REG_W-1:0]         rs_p0;
   logic [REG_W-1:0]         rt_p0;
   logic [REG_W-1:0]         rd_p0;
   logic signed [DATA_W-1:0] rs_data_p0;
   logic signed [DATA_W-1:0] rt_data_p0;
   logic [15:0]              imm_p0;
   logic [4:0]               shamt_p0;
   logic                     reg_write_p0;
   logic                     mem_read_p0;
   logic                     mem_write_p0;

   logic signed [DATA_W-1:0] fwd_rs;
   logic signed [DATA_W-1:0] fwd_rt;
   logic signed [DATA_W-1:0] op1;
   logic signed [DATA_W-1:0] op2;

   function automatic logic signed [DATA_W-1:0] sext_imm(input logic [15:0] imm);
      return {{(DATA_W-16){imm[15]}}, imm};
   endfunction

   function automatic logic signed [DATA_W-1:0] zext_imm(input logic [15:0] imm);
      return {{(DATA_W-16){1'b0}}, imm};
   endfunction

   function automatic logic signed [DATA_W-1:0] zext_shamt(input logic [4:0] sh);
      return {{(DATA_W-5){1'b0}}, sh};
   endfunction

   // Pick the youngest in-flight producer of src; register 0 is never forwarded.
   function automatic logic signed [DATA_W-1:0] fwd_sel(
      input logic [REG_W-1:0]         src,
      input logic signed [DATA_W-1:0] captured,
      input logic                     em_we,
      input logic [REG_W-1:0]         em_rd,
      input logic [DATA_W-1:0]        em_val,
      input logic                     mw_we,
      input logic [REG_W-1:0]         mw_rd,
      input logic [DATA_W-1:0]        mw_val
   );
      if (src != '0 && em_we && em_rd == src)
         return em_val;
      else if (src != '0 && mw_we && mw_rd == src)
         return mw_val;
      else
         return captured;
   endfunction

   // ---- ID -> EX boundary: capture decode outputs (reset > flush > stall > load)
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         vld_p0       <= 1'b0;
         alu_ctrl_p0  <= '0;
         rs_p0        <= '0;
         rt_p0        <= '0;
         rd_p0        <= '0;
         rs_data_p0   <= '0;
         rt_data_p0   <= '0;
         imm_p0       <= '0;
         shamt_p0     <= '0;
         reg_write_p0 <= 1'b0;
         mem_read_p0  <= 1'b0;
         mem_write_p0 <= 1'b0;
      end else if (!stall) begin
         vld_p0       <= id_valid;
         alu_ctrl_p0  <= id_valid ? id_alu_control : 5'd0;
         rs_p0        <= id_rs;
         rt_p0        <= id_rt;
         rd_p0        <= id_rd;
         rs_data_p0   <= id_rs_data;
         rt_data_p0   <= id_rt_data;
         imm_p0       <= id_imm;
         shamt_p0     <= id_shamt;
         reg_write_p0 <= id_reg_write & id_valid;
         mem_read_p0  <= id_mem_read & id_valid;
         mem_write_p0 <= id_mem_write & id_valid;
      end
   end

   // Forward the registered source values from EX/MEM first, then MEM/WB
   always_comb begin
      fwd_rs = fwd_sel(rs_p0, rs_data_p0, exmem_reg_write, exmem_rd, exmem_result,
                       memwb_reg_write, memwb_rd, memwb_data);
      fwd_rt = fwd_sel(rt_p0, rt_data_p0, exmem_reg_write, exmem_rd, exmem_result,
                       memwb_reg_write, memwb_rd, memwb_data);
   end

   // Operand selection by ALU code; unknown codes drive zero operands
   always_comb begin
      op1 = '0;
      op2 = '0;
      if (alu_ctrl_p0 >= OP_R_FIRST && alu_ctrl_p0 <= OP_R_LAST) begin
         op1 = fwd_rs;
         op2 = fwd_rt;
      end else begin
         case (alu_ctrl_p0)
            OP_SLTI, OP_ADDI: begin
               op1 = fwd_rs;
               op2 = sext_imm(imm_p0);
            end
            OP_ANDI, OP_ORI: begin
               op1 = fwd_rs;
               op2 = zext_imm(imm_p0);
            end
            OP_SLL, OP_SRL, OP_SRA: begin
               op1 = fwd_rt;
               op2 = zext_shamt(shamt_p0);
            end
            OP_LUI: begin
               op1 = '0;
               op2 = zext_imm(imm_p0);
            end
            default: begin
               op1 = '0;
               op2 = '0;
            end
         endcase
      end
   end

   // Load in EX whose destination decode is about to read needs a one-cycle stall
   always_comb begin
      load_use_hazard = vld_p0 && mem_read_p0 && (rd_p0 != '0) && id_valid &&
                        ((rd_p0 == id_rs) || (rd_p0 == id_rt));
   end

   assign alu_input1    = op1;
   assign alu_input2    = op2;
   assign alu_control   = alu_ctrl_p0;
   assign ex_valid      = vld_p0;
   assign ex_reg_write  = reg_write_p0;
   assign ex_mem_read   = mem_read_p0;
   assign ex_mem_write  = mem_write_p0;
   assign ex_rd         = rd_p0;
   assign ex_store_data = fwd_rt;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed bench for alu_operand_stage with a behavioural reference model.
module tb_alu_operand_stage;

   logic        clk = 1'b0;
   logic        reset, stall, flush, id_valid;
   logic [4:0]  id_alu_control, id_rs, id_rt, id_rd, id_shamt;
   logic [31:0] id_rs_data, id_rt_data;
   logic [15:0] id_imm;
   logic        id_reg_write, id_mem_read, id_mem_write;
   logic        exmem_reg_write, memwb_reg_write;
   logic [4:0]  exmem_rd, memwb_rd;
   logic [31:0] exmem_result, memwb_data;
   logic [31:0] alu_input1, alu_input2, ex_store_data;
   logic [4:0]  alu_control, ex_rd;
   logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, load_use_hazard;

   int errors = 0;
   int checks = 0;

   alu_operand_stage #(.DATA_W(32), .REG_W(5)) dut (
      .clk(clk), .reset(reset), .stall(stall), .flush(flush), .id_valid(id_valid),
      .id_alu_control(id_alu_control), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
      .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
      .id_shamt(id_shamt), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
      .id_mem_write(id_mem_write), .exmem_reg_write(exmem_reg_write),
      .exmem_rd(exmem_rd), .exmem_result(exmem_result),
      .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_data(memwb_data),
      .alu_input1(alu_input1), .alu_input2(alu_input2), .alu_control(alu_control),
      .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
      .ex_mem_write(ex_mem_write), .ex_rd(ex_rd), .ex_store_data(ex_store_data),
      .load_use_hazard(load_use_hazard)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Reference model: the instruction the stage is holding
   typedef struct {
      bit        valid;
      bit [4:0]  code;
      bit [4:0]  rs, rt, rd;
      bit [31:0] rsd, rtd;
      bit [15:0] imm;
      bit [4:0]  shamt;
      bit        rw, mr, mw;
   } held_t;

   held_t m;

   initial begin
      m = '{default: 0};
   end

   always @(posedge clk) begin
      if (reset || flush) begin
         m <= '{default: 0};
      end else if (!stall) begin
         m <= '{valid: id_valid, code: id_valid ? id_alu_control : 5'd0,
                rs: id_rs, rt: id_rt, rd: id_rd, rsd: id_rs_data, rtd: id_rt_data,
                imm: id_imm, shamt: id_shamt, rw: id_reg_write && id_valid,
                mr: id_mem_read && id_valid, mw: id_mem_write && id_valid};
      end
   end

   function automatic bit [31:0] src_value(bit [4:0] r, bit [31:0] captured);
      if (r == 0) return captured;
      if (exmem_reg_write && exmem_rd == r) return exmem_result;
      if (memwb_reg_write && memwb_rd == r) return memwb_data;
      return captured;
   endfunction

   function automatic bit [63:0] expected_operands();
      bit [31:0] a, b, s, t;
      a = src_value(m.rs, m.rsd);
      b = src_value(m.rt, m.rtd);
      s = 32'(int'($signed(m.imm)));
      t = 32'(m.imm);
      case (int'(m.code))
         1, 2, 3, 4, 5: return {a, b};
         6, 7:          return {a, s};
         8, 9:          return {a, t};
         10, 11, 12:    return {b, 32'(m.shamt)};
         13:            return {32'd0, t};
         default:       return 64'd0;
      endcase
   endfunction

   // Compare every output against the model on the falling edge
   always @(negedge clk) begin
      bit [63:0] ops;
      bit        hz;
      ops = expected_operands();
      hz  = m.valid && m.mr && m.rd != 0 && id_valid && (m.rd == id_rs || m.rd == id_rt);
      chk("m_input1", alu_input1, ops[63:32]);
      chk("m_input2", alu_input2, ops[31:0]);
      chk("m_control", 32'(alu_control), 32'(m.code));
      chk("m_valid", 32'(ex_valid), 32'(m.valid));
      chk("m_reg_write", 32'(ex_reg_write), 32'(m.rw));
      chk("m_mem_read", 32'(ex_mem_read), 32'(m.mr));
      chk("m_mem_write", 32'(ex_mem_write), 32'(m.mw));
      chk("m_rd", 32'(ex_rd), 32'(m.rd));
      chk("m_store", ex_store_data, src_value(m.rt, m.rtd));
      chk("m_hazard", 32'(load_use_hazard), 32'(hz));
   end

   task automatic instr(input logic [4:0] code, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [31:0] rsd, input logic [31:0] rtd,
                        input logic [15:0] imm, input logic [4:0] sh,
                        input logic rw, input logic mr, input logic mw);
      id_valid = 1'b1; id_alu_control = code;
      id_rs = rs; id_rt = rt; id_rd = rd; id_rs_data = rsd; id_rt_data = rtd;
      id_imm = imm; id_shamt = sh; id_reg_write = rw; id_mem_read = mr; id_mem_write = mw;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic no_fwd();
      exmem_reg_write = 1'b0; exmem_rd = 5'd0; exmem_result = 32'hDEAD0001;
      memwb_reg_write = 1'b0; memwb_rd = 5'd0; memwb_data = 32'hDEAD0002;
   endtask

   initial begin
      reset = 1'b1; stall = 1'b0; flush = 1'b0;
      no_fwd();
      instr(5'd7, 5'd3, 5'd4, 5'd6, 32'h10, 32'h20, 16'hFFFF, 5'd0, 1'b1, 1'b0, 1'b0);
      tick(); tick(); tick();
      chk("rst_valid", 32'(ex_valid), 32'd0);
      chk("rst_control", 32'(alu_control), 32'd0);
      chk("rst_input1", alu_input1, 32'd0);
      chk("rst_input2", alu_input2, 32'd0);

      // addi: first capture after reset release
      reset = 1'b0;
      tick();
      chk("addi_input1", alu_input1, 32'h10);
      chk("addi_input2", alu_input2, 32'hFFFFFFFF);
      chk("addi_control", 32'(alu_control), 32'd7);
      chk("addi_valid", 32'(ex_valid), 32'd1);

      // ori zero-extends
      instr(5'd9, 5'd3, 5'd4, 5'd6, 32'h10, 32'h20, 16'hFFFF, 5'd0, 1'b1, 1'b0, 1'b0);
      tick();
      chk("ori_input2", alu_input2, 32'h0000FFFF);

      // double forward, EX/MEM wins
      instr(5'd1, 5'd5, 5'd5, 5'd2, 32'h55, 32'h66, 16'h0, 5'd0, 1'b1, 1'b0, 1'b0);
      exmem_reg_write = 1'b1; exmem_rd = 5'd5; exmem_result = 32'hAAAA0000;
      memwb_reg_write = 1'b1; memwb_rd = 5'd5; memwb_data = 32'h1234;
      tick();
      chk("fwd_em_in1", alu_input1, 32'hAAAA0000);
      chk("fwd_em_in2", alu_input2, 32'hAAAA0000);
      exmem_reg_write = 1'b0;
      #1;
      chk("fwd_mw_in1", alu_input1, 32'h1234);
      chk("fwd_mw_in2", alu_input2, 32'h1234);
      chk("fwd_mw_store", ex_store_data, 32'h1234);

      // register 0 is never forwarded
      instr(5'd1, 5'd0, 5'd0, 5'd2, 32'h77, 32'h88, 16'h0, 5'd0, 1'b1, 1'b0, 1'b0);
      exmem_reg_write = 1'b1; exmem_rd = 5'd0;
      memwb_reg_write = 1'b1; memwb_rd = 5'd0;
      tick();
      chk("r0_input1", alu_input1, 32'h77);
      chk("r0_input2", alu_input2, 32'h88);

      // shift and lui
      no_fwd();
      instr(5'd10, 5'd1, 5'd2, 5'd3, 32'h99, 32'h1, 16'h0, 5'd31, 1'b1, 1'b0, 1'b0);
      tick();
      chk("sll_input1", alu_input1, 32'h1);
      chk("sll_input2", alu_input2, 32'd31);
      instr(5'd13, 5'd1, 5'd2, 5'd3, 32'h99, 32'h1, 16'h8000, 5'd0, 1'b1, 1'b0, 1'b0);
      tick();
      chk("lui_input1", alu_input1, 32'd0);
      chk("lui_input2", alu_input2, 32'h00008000);

      // unknown code and invalid slot
      instr(5'd31, 5'd1, 5'd2, 5'd3, 32'h99, 32'h1, 16'h1234, 5'd3, 1'b1, 1'b0, 1'b0);
      tick();
      chk("bad_input1", alu_input1, 32'd0);
      chk("bad_input2", alu_input2, 32'd0);
      instr(5'd7, 5'd1, 5'd2, 5'd3, 32'h99, 32'h1, 16'h1234, 5'd3, 1'b1, 1'b1, 1'b1);
      id_valid = 1'b0;
      tick();
      chk("inv_control", 32'(alu_control), 32'd0);
      chk("inv_reg_write", 32'(ex_reg_write), 32'd0);
      chk("inv_input2", alu_input2, 32'd0);

      // stall holds A while decode changes to B
      instr(5'd7, 5'd4, 5'd2, 5'd9, 32'h100, 32'h1, 16'h5, 5'd0, 1'b1, 1'b0, 1'b0);
      tick();
      stall = 1'b1;
      instr(5'd9, 5'd6, 5'd2, 5'd11, 32'h200, 32'h1, 16'h7, 5'd0, 1'b0, 1'b0, 1'b1);
      tick(); tick(); tick();
      chk("stall_input1", alu_input1, 32'h100);
      chk("stall_input2", alu_input2, 32'h5);
      chk("stall_rd", 32'(ex_rd), 32'd9);
      chk("stall_control", 32'(alu_control), 32'd7);
      flush = 1'b1;
      tick();
      chk("flush_valid", 32'(ex_valid), 32'd0);
      chk("flush_reg_write", 32'(ex_reg_write), 32'd0);
      chk("flush_control", 32'(alu_control), 32'd0);
      flush = 1'b0; stall = 1'b0;

      // load-use hazard
      instr(5'd7, 5'd1, 5'd2, 5'd7, 32'h40, 32'h0, 16'h4, 5'd0, 1'b1, 1'b1, 1'b0);
      tick();
      instr(5'd1, 5'd7, 5'd3, 5'd4, 32'h0, 32'h0, 16'h0, 5'd0, 1'b1, 1'b0, 1'b0);
      #1;
      chk("lu_hit", 32'(load_use_hazard), 32'd1);
      id_rs = 5'd8; id_rt = 5'd8;
      #1;
      chk("lu_miss", 32'(load_use_hazard), 32'd0);
      id_rt = 5'd7; id_valid = 1'b0;
      #1;
      chk("lu_invalid", 32'(load_use_hazard), 32'd0);
      instr(5'd7, 5'd1, 5'd2, 5'd0, 32'h40, 32'h0, 16'h4, 5'd0, 1'b1, 1'b1, 1'b0);
      tick();
      id_rs = 5'd0; id_rt = 5'd0;
      #1;
      chk("lu_rd0", 32'(load_use_hazard), 32'd0);

      // reset mid-operation discards the held load
      instr(5'd7, 5'd1, 5'd2, 5'd7, 32'h40, 32'h0, 16'h4, 5'd0, 1'b1, 1'b1, 1'b0);
      tick();
      reset = 1'b1;
      tick();
      chk("rst_mid_valid", 32'(ex_valid), 32'd0);
      chk("rst_mid_mem_read", 32'(ex_mem_read), 32'd0);
      reset = 1'b0;
      tick();
      chk("rst_mid_recapture", 32'(ex_valid), 32'd1);
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
